uart_word_link: RTL and testbench
=================================

// Module: uart_word_link
// PURPOSE
//  Serial peripheral answering the control unit's UART commands. Sends and receives 16-bit words
//  as two 8N1 bytes, low byte first, on txd/rxd; signals completion on uart_done.
//  Sits between the control unit/bus (uart_receive, uart_in_and_send, uart_out) and the board pins.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per serial bit (50 MHz / 115200); legal range >= 4
// PORTS
//  clk               in   1   system clock; all logic on posedge
//  reset             in   1   asynchronous, active-high reset
//  uart_receive      in   1   1-cycle command: receive one 16-bit word
//  uart_in_and_send  in   1   1-cycle command: latch data_in and transmit it
//  uart_out          in   1   drive received word onto bus this cycle
//  data_in           in   16  bus word, sampled on the uart_in_and_send cycle
//  data_out          out  16  last received word (0 after reset)
//  data_out_en       out  1   = uart_out; bus tri-state enable
//  uart_done         out  1   1-cycle pulse: current transaction finished
//  rxd               in   1   serial input, asynchronous, idle high
//  txd               out  1   serial output, idle high
// BEHAVIOUR
//  Reset values: txd=1, uart_done=0, data_out=0, both engines IDLE, tx/rx shift regs 0.
//  Reset mid-frame aborts at once; txd returns high asynchronously.
//  One transaction at a time. Commands arriving while BUSY are ignored.
//  If both commands arrive in the same cycle, receive wins.
//  TX FSM: IDLE -> START -> DATA(8) -> STOP -> (byte 1 done ? START of byte 2 : DONE) -> IDLE.
//   - data_in latched on command cycle; first START bit drives txd on the next cycle.
//   - Each bit is held exactly CLKS_PER_BIT cycles; LSB first; low byte then high byte.
//   - No idle gap between bytes.
//   - uart_done pulses in the cycle after the second stop bit ends.
//   - Total latency: 20*CLKS_PER_BIT+1 cycles from command to uart_done.
//  RX FSM: IDLE -> HUNT -> START -> DATA(8) -> STOP -> (byte count) -> DONE -> IDLE.
//   - rxd passes through a 2-flop synchronizer; rxd is ignored while IDLE, so bytes arriving
//     uncommanded are dropped.
//   - HUNT waits for a falling edge. START re-samples at CLKS_PER_BIT/2; if high, it is a glitch
//     and the FSM returns to HUNT.
//   - Data bits are sampled mid-bit, every CLKS_PER_BIT cycles.
//   - STOP sampled 0 = framing error: discard the byte and return to HUNT for the same byte index.
//   - After the high byte's stop sample, data_out <= {hi,lo}. uart_done pulses the same cycle.
//   - data_out is unchanged until the next full word; there is no timeout (the control unit waits).
//  uart_done is never asserted in the command cycle itself (min latency > 1), so the control unit's
//  wait state always sees it.
// CONFIGURATION
//  UART_PARITY_EN defined: every byte carries an even-parity bit between the last data bit and
//  the stop bit (frame = 11 bits).
//   - TX latency becomes 22*CLKS_PER_BIT+1.
//   - RX: a parity mismatch is handled like a framing error (discard, rehunt same byte).
//  UART_PARITY_EN undefined: pure 8N1, no parity logic synthesized.
// STRUCTURE
//  uart_pkg: TX/RX state localparams, frame constants (DATA_BITS=8, BYTES_PER_WORD=2), and
//  the parity-bit count derived from UART_PARITY_EN.
//  Sub-module uart_bit_timer:
//   - Cycle counter with load of full or half period; emits tick at expiry.
//   - Instantiated twice, once for TX and once for RX.
// TESTING (bench uses CLKS_PER_BIT=4)
//  1. reset high mid-TX of 16'hA55A
//     -> txd=1 and uart_done=0 immediately; no further activity after reset release.
//  2. uart_in_and_send with data_in=16'h1234
//     -> txd shows 0,0x34 LSB-first,1,0,0x12,1, each bit 4 cycles.
//     -> uart_done pulses exactly once, 81 cycles after the command.
//  3. uart_receive, then the bench drives bytes 0xCD, 0xAB
//     -> uart_done pulses at the 2nd stop sample and data_out=16'hABCD.
//     -> uart_out=1 gives data_out_en=1.
//  4. uart_receive; 1-cycle low glitch on rxd, then a byte with stop=0, then valid 0x01, 0x80
//     -> glitch and bad byte ignored; data_out=16'h8001 and exactly one uart_done.
//  5. uart_in_and_send re-issued during TX, and uart_receive + uart_in_and_send in the same cycle
//     -> second command ignored; receive chosen and txd stays 1.
//  6. UART_PARITY_EN: send 16'h0703
//     -> parity bits 0 then 1; an RX byte with flipped parity is discarded.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, state encodings and helpers for the UART word link.
// Build option: define UART_PARITY_EN to add an even-parity bit per byte.
package uart_pkg;

    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 2;

`ifdef UART_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // start + data + optional parity + stop
    localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_DONE
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_HUNT,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_DONE
    } rx_state_e;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter shared by the TX and RX engines.
// Ports: clk, reset (async, active-high); load_full_i / load_half_i preload
// a full or half bit period; en_i runs the counter; tick_o marks expiry and
// the counter then reloads a full period by itself.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic load_full_i,
    input  logic load_half_i,
    input  logic en_i,
    output logic tick_o
);
    import uart_pkg::*;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_full_i) begin
            cnt_d = FULL;
        end else if (load_half_i) begin
            cnt_d = HALF;
        end else if (en_i) begin
            // free-running reload keeps back-to-back bits exactly spaced
            cnt_d = (cnt_q == '0) ? FULL : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_word_link.sv
// UART peripheral moving 16-bit words as two bytes (low first) for the CU.
// Ports: clk, reset (async, active-high); uart_receive / uart_in_and_send
// are 1-cycle commands; uart_out drives data_out_en; data_in sampled on the
// send command; data_out holds the last received word; uart_done pulses at
// the end of each transaction; rxd / txd are the serial pins (idle high).
// Build option: UART_PARITY_EN inserts an even-parity bit before each stop.
module uart_word_link #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_receive,
    input  logic        uart_in_and_send,
    input  logic        uart_out,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_out_en,
    output logic        uart_done,
    input  logic        rxd,
    output logic        txd
);
    import uart_pkg::*;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // ---------------- command arbitration ----------------
    tx_state_e tx_state_q;
    rx_state_e rx_state_q;
    logic      idle;
    logic      rx_go;
    logic      tx_go;

    assign idle  = (tx_state_q == TX_IDLE) && (rx_state_q == RX_IDLE);
    // receive wins a same-cycle collision
    assign rx_go = idle && uart_receive;
    assign tx_go = idle && uart_in_and_send && !uart_receive;

    // ---------------- TX engine ----------------
    logic [15:0] tx_shift_q;
    logic [2:0]  tx_bit_q;
    logic        tx_byte_q;
    logic        txd_q;
    logic        tx_done_q;
    logic        tx_tick;
    logic        tx_timer_en;
`ifdef UART_PARITY_EN
    logic        tx_par_q;
`endif

    assign tx_timer_en = (tx_state_q != TX_IDLE) && (tx_state_q != TX_DONE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_timer (
        .clk        (clk),
        .reset      (reset),
        .load_full_i(tx_go),
        .load_half_i(1'b0),
        .en_i       (tx_timer_en),
        .tick_o     (tx_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= 1'b0;
            txd_q      <= 1'b1;
            tx_done_q  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_done_q <= 1'b0;
            unique case (tx_state_q)
                TX_IDLE: begin
                    if (tx_go) begin
                        tx_shift_q <= data_in;
                        tx_byte_q  <= 1'b0;
                        txd_q      <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        txd_q      <= tx_shift_q[0];
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
`ifdef UART_PARITY_EN
                        tx_par_q   <= even_parity(tx_shift_q[7:0]);
`endif
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        // word shifts right; high byte lands in [7:0]
                        tx_shift_q <= {1'b0, tx_shift_q[15:1]};
                        tx_bit_q   <= tx_bit_q + 3'd1;
                        if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            txd_q      <= tx_par_q;
                            tx_state_q <= TX_PARITY;
`else
                            txd_q      <= 1'b1;
                            tx_state_q <= TX_STOP;
`endif
                        end else begin
                            txd_q <= tx_shift_q[1];
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_tick) begin
                        txd_q      <= 1'b1;
                        tx_state_q <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        if (!tx_byte_q) begin
                            // second byte follows with no idle gap
                            tx_byte_q  <= 1'b1;
                            txd_q      <= 1'b0;
                            tx_state_q <= TX_START;
                        end else begin
                            tx_done_q  <= 1'b1;
                            tx_state_q <= TX_DONE;
                        end
                    end
                end
                TX_DONE: begin
                    tx_state_q <= TX_IDLE;
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    // ---------------- RX synchronizer ----------------
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;
    logic rx_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q && !rx_sync_q;

    // ---------------- RX engine ----------------
    logic [7:0]  rx_shift_q;
    logic [7:0]  rx_lo_q;
    logic [2:0]  rx_bit_q;
    logic        rx_byte_q;
    logic [15:0] data_out_q;
    logic        rx_done_q;
    logic        rx_tick;
    logic        rx_timer_en;
    logic        rx_load_half;
    logic        rx_frame_ok;
`ifdef UART_PARITY_EN
    logic        rx_bad_q;
    assign rx_frame_ok = rx_sync_q && !rx_bad_q;
`else
    assign rx_frame_ok = rx_sync_q;
`endif

    assign rx_load_half = (rx_state_q == RX_HUNT) && rx_fall;
    assign rx_timer_en  = (rx_state_q == RX_START) ||
                          (rx_state_q == RX_DATA)  ||
                          (rx_state_q == RX_PARITY) ||
                          (rx_state_q == RX_STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_timer (
        .clk        (clk),
        .reset      (reset),
        .load_full_i(1'b0),
        .load_half_i(rx_load_half),
        .en_i       (rx_timer_en),
        .tick_o     (rx_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_lo_q    <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= 1'b0;
            data_out_q <= '0;
            rx_done_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_bad_q   <= 1'b0;
`endif
        end else begin
            rx_done_q <= 1'b0;
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (rx_go) begin
                        rx_byte_q  <= 1'b0;
                        rx_state_q <= RX_HUNT;
                    end
                end
                RX_HUNT: begin
                    if (rx_fall) begin
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    // a start bit gone high by mid-bit was a glitch
                    if (rx_tick) begin
                        if (!rx_sync_q) begin
                            rx_bit_q   <= '0;
                            rx_state_q <= RX_DATA;
                        end else begin
                            rx_state_q <= RX_HUNT;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            rx_state_q <= RX_PARITY;
`else
                            rx_state_q <= RX_STOP;
`endif
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_tick) begin
`ifdef UART_PARITY_EN
                        rx_bad_q <= rx_sync_q ^ even_parity(rx_shift_q);
`endif
                        rx_state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        if (!rx_frame_ok) begin
                            // bad byte: rehunt for the same byte index
                            rx_state_q <= RX_HUNT;
                        end else if (!rx_byte_q) begin
                            rx_lo_q    <= rx_shift_q;
                            rx_byte_q  <= 1'b1;
                            rx_state_q <= RX_HUNT;
                        end else begin
                            data_out_q <= {rx_shift_q, rx_lo_q};
                            rx_done_q  <= 1'b1;
                            rx_state_q <= RX_DONE;
                        end
                    end
                end
                RX_DONE: begin
                    rx_state_q <= RX_IDLE;
                end
                default: begin
                    rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign txd         = txd_q;
    assign uart_done   = tx_done_q | rx_done_q;
    assign data_out    = data_out_q;
    assign data_out_en = uart_out;

endmodule

// File: tb/tb_uart_word_link.sv
// Directed bench for uart_word_link with a cycle-level reference model.
// Model: transmit frame timeline, done cycles and the last received word.
module tb_uart_word_link;

    localparam int K = 4;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 2 * (10 + PB);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_receive = 1'b0;
    logic        uart_in_and_send = 1'b0;
    logic        uart_out = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        data_out_en;
    logic        uart_done;
    logic        rxd = 1'b1;
    logic        txd;

    uart_word_link #(
        .CLKS_PER_BIT(K)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .uart_receive    (uart_receive),
        .uart_in_and_send(uart_in_and_send),
        .uart_out        (uart_out),
        .data_in         (data_in),
        .data_out        (data_out),
        .data_out_en     (data_out_en),
        .uart_done       (uart_done),
        .rxd             (rxd),
        .txd             (txd)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // reference model state
    logic        frame [0:43];
    int          tx_cmd = -100000;
    int          done_at = -1;
    int          word_at = -1;
    logic [15:0] pend_word = '0;
    logic [15:0] exp_data = '0;
    int          done_cnt = 0;
    int          last_done = -1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic void build_frame(input logic [15:0] w);
        int p;
        logic [7:0] by;
        p = 0;
        for (int b = 0; b < 2; b++) begin
            by = w[8*b +: 8];
            frame[p] = 1'b0;
            p = p + 1;
            for (int i = 0; i < 8; i++) begin
                frame[p] = by[i];
                p = p + 1;
            end
            if (PB != 0) begin
                frame[p] = ^by;
                p = p + 1;
            end
            frame[p] = 1'b1;
            p = p + 1;
        end
    endfunction

    // compare process: every cycle, after the edge settles
    initial begin
        logic e_txd;
        int   d;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == word_at) exp_data = pend_word;
            d = cyc - tx_cmd;
            e_txd = (d >= 0 && d < NB * K) ? frame[d / K] : 1'b1;
            chk("txd", txd, e_txd);
            chk("uart_done", uart_done, cyc == done_at);
            chk("data_out", data_out, exp_data);
            chk("data_out_en", data_out_en, uart_out);
            if (uart_done) begin
                done_cnt++;
                last_done = cyc;
            end
        end
    end

    // leaves the caller at the negedge of the first cycle after the command
    task automatic send(input logic [15:0] w, input bit accept);
        @(negedge clk);
        data_in = w;
        uart_in_and_send = 1'b1;
        if (accept) begin
            build_frame(w);
            tx_cmd  = cyc + 1;
            done_at = tx_cmd + NB * K;
        end
        @(negedge clk);
        uart_in_and_send = 1'b0;
    endtask

    task automatic rx_cmd();
        @(negedge clk);
        uart_receive = 1'b1;
        @(negedge clk);
        uart_receive = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (K) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // last: this byte completes the word; done expected at the stop sample
    // (2 synchronizer cycles plus half a bit after the stop bit starts)
    task automatic drive_byte(input logic [7:0] b, input logic stop,
                              input logic pflip, input bit last,
                              input logic [15:0] word);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PB != 0) drive_bit((^b) ^ pflip);
        if (last) begin
            pend_word = word;
            word_at   = cyc + 1 + 2 + K / 2;
            done_at   = word_at;
        end
        drive_bit(stop);
    endtask

    initial begin
        logic [31:0] v;
        int          c0;
        int          lat;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_done", uart_done, 0);
        chk("rst_data_out", data_out, 16'h0000);
        reset = 1'b0;
        @(negedge clk);

        // 1: reset in the middle of a transmit
        send(16'hA55A, 1'b1);
        @(negedge clk);
        chk("t1_start_bit", txd, 0);
        reset   = 1'b1;
        tx_cmd  = -100000;
        done_at = -1;
        word_at = -1;
        exp_data = '0;
        #1;
        chk("t1_async_txd", txd, 1);
        chk("t1_async_done", uart_done, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        c0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("t1_quiet", done_cnt - c0, 0);

        // 2: transmit 16'h1234, sampled mid-bit
        c0 = done_cnt;
        send(16'h1234, 1'b1);
        v = '0;
        @(negedge clk);
        for (int j = 0; j < NB; j++) begin
            v[j] = txd;
            repeat (K) @(negedge clk);
        end
        repeat (8) @(negedge clk);
`ifdef UART_PARITY_EN
        chk("t2_bits", v, {10'd0, 1'b1, 1'b0, 8'h12, 1'b0,
                           1'b1, 1'b1, 8'h34, 1'b0});
        lat = 89;
`else
        chk("t2_bits", v, {12'd0, 1'b1, 8'h12, 1'b0,
                           1'b1, 8'h34, 1'b0});
        lat = 81;
`endif
        chk("t2_done_count", done_cnt - c0, 1);
        chk("t2_latency", last_done - (tx_cmd - 1), lat);

        // 3: receive 0xCD then 0xAB
        c0 = done_cnt;
        rx_cmd();
        idle(5);
        drive_byte(8'hCD, 1'b1, 1'b0, 1'b0, 16'h0);
        drive_byte(8'hAB, 1'b1, 1'b0, 1'b1, 16'hABCD);
        idle(10);
        chk("t3_data_out", data_out, 16'hABCD);
        chk("t3_done_count", done_cnt - c0, 1);
        uart_out = 1'b1;
        #1;
        chk("t3_out_en", data_out_en, 1);
        @(negedge clk);
        uart_out = 1'b0;

        // 4: glitch, framing error, then 0x01 0x80
        c0 = done_cnt;
        rx_cmd();
        idle(5);
        rxd = 1'b0;
        @(negedge clk);
        idle(8);
        drive_byte(8'h55, 1'b0, 1'b0, 1'b0, 16'h0);
        idle(6);
        drive_byte(8'h01, 1'b1, 1'b0, 1'b0, 16'h0);
        drive_byte(8'h80, 1'b1, 1'b0, 1'b1, 16'h8001);
        idle(10);
        chk("t4_data_out", data_out, 16'h8001);
        chk("t4_done_count", done_cnt - c0, 1);

        // 5: commands while busy and same-cycle collision
        c0 = done_cnt;
        send(16'h00FF, 1'b1);
        repeat (10) @(negedge clk);
        send(16'hBEEF, 1'b0);
        repeat (NB * K) @(negedge clk);
        chk("t5_done_count", done_cnt - c0, 1);
        chk("t5_latency", last_done - (tx_cmd - 1), lat);
        c0 = done_cnt;
        @(negedge clk);
        uart_receive = 1'b1;
        uart_in_and_send = 1'b1;
        data_in = 16'h3C3C;
        @(negedge clk);
        uart_receive = 1'b0;
        uart_in_and_send = 1'b0;
        idle(20);
        chk("t5_txd_idle", txd, 1);
        send(16'hFFFF, 1'b0);
        idle(4);
        drive_byte(8'hA5, 1'b1, 1'b0, 1'b0, 16'h0);
        drive_byte(8'h5A, 1'b1, 1'b0, 1'b1, 16'h5AA5);
        idle(10);
        chk("t5_data_out", data_out, 16'h5AA5);
        chk("t5_rx_done_count", done_cnt - c0, 1);

`ifdef UART_PARITY_EN
        // 6: parity bits on transmit, bad parity on receive
        send(16'h0703, 1'b1);
        repeat (9 * K + 1) @(negedge clk);
        chk("t6_par_lo", txd, 0);
        repeat (11 * K) @(negedge clk);
        chk("t6_par_hi", txd, 1);
        repeat (2 * K + 5) @(negedge clk);
        c0 = done_cnt;
        rx_cmd();
        idle(5);
        drive_byte(8'h11, 1'b1, 1'b1, 1'b0, 16'h0);
        idle(4);
        drive_byte(8'h22, 1'b1, 1'b0, 1'b0, 16'h0);
        drive_byte(8'h33, 1'b1, 1'b0, 1'b1, 16'h3322);
        idle(10);
        chk("t6_data_out", data_out, 16'h3322);
        chk("t6_done_count", done_cnt - c0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
